mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ALUCW, default 3: ALUControl width; SHALL be at least 3, and bits above [2] SHALL be driven 0.
REQ-002 Parameter FP_EN, default 1: when 1, Op=2'b11 is decoded as a floating-point data-processing instruction; when 0, Op=2'b11 is undefined.
REQ-003 clk  in  1: the single clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 Instr  in  [31:12]: instruction fields: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]; sampled from the IR.
REQ-006 ALUFlags  in  [3:0]: ALU result flags {N,Z,C,V}.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite  out  1 each: state-element write enables.
REQ-008 AdrSrc, ALUSrcA, FP  out  1 each: datapath selects; FP marks an FP operation.
REQ-009 ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  [1:0] each: datapath selects.
REQ-010 ALUControl  out  [ALUCW-1:0]: ALU operation select.
REQ-011 State  out  [3:0]: current FSM state, for debug.

Function
REQ-012 FSM states and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, EXECF=8, ALUWB=9, BRANCH=10; encodings 11-15 SHALL go to FETCH on the next clock.
REQ-013 FETCH SHALL always go to DECODE. It SHALL drive AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, PCWrite=1, and ALU add.
REQ-014 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add, with next state chosen by Op:
  - Op=01 -> MEMADR
  - Op=00 with Funct[5]=0 -> EXECR
  - Op=00 with Funct[5]=1 -> EXECI
  - Op=10 -> BRANCH
  - Op=11 with FP_EN=1 -> EXECF
  - Op=11 with FP_EN=0 -> FETCH
REQ-015 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALU add; it SHALL go to MEMRD if Funct[0]=1, else to MEMWR.
REQ-016 Memory states SHALL behave as follows:
  - MEMRD: AdrSrc=1, ResultSrc=00; next state MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=CondEx; next state FETCH.
  - MEMWR: AdrSrc=1, MemWrite=CondEx; next state FETCH.
REQ-017 Execute states SHALL all go to ALUWB, driving ALUSrcA=0 and the decoded ALU operation:
  - EXECR: ALUSrcB=00.
  - EXECI: ALUSrcB=01.
  - EXECF: ALUSrcB=00, FP=1.
REQ-018 ALUWB SHALL drive ResultSrc=00 and RegWrite=CondEx, and SHALL additionally assert PCWrite=CondEx when Rd=15; next state FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALU add, PCWrite=CondEx; next state FETCH.
REQ-020 In every state not named above, every enable and select SHALL be 0, and ALUControl SHALL be 0 (add).
REQ-021 Decoded ALU operation, selected by Funct[4:1]:
  - 0100 ADD=0
  - 0010 SUB=1
  - 0000 AND=2
  - 1100 ORR=3
  - any other value = 7 (undefined)
REQ-022 FP decode: in EXECF, ALUControl SHALL be Funct[3:1] (the FP op select).
REQ-023 ImmSrc and RegSrc are combinational functions of Op (ImmSrc=Op; RegSrc={Op==01, Op==10}) and SHALL hold in every state, including FETCH.
REQ-024 CondEx SHALL be registered at the end of DECODE, computed from Cond and the stored flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; Cond=1111 gives 0
REQ-025 Flag register [3:0] SHALL be updated only at the end of EXECR, EXECI or EXECF, and only when Funct[0]=1 (S) and CondEx=1:
  - N and Z are always written.
  - C and V are written only for ADD or SUB.
REQ-026 Simultaneous events: flags updated in one instruction's execute state SHALL be visible to the CondEx evaluation of the next instruction's DECODE.
REQ-027 Latencies SHALL be, per instruction:
  - LDR 5 cycles
  - STR 4 cycles
  - data-processing (register, immediate or FP) 4 cycles
  - branch 3 cycles
  - undefined 2 cycles

Reset
REQ-028 While reset=1 at a clock edge, the following SHALL all be cleared to 0: State (=FETCH), the flag register, and CondEx.
REQ-029 A reset asserted mid-instruction SHALL abort that instruction; no RegWrite, MemWrite or PCWrite pulse belonging to it SHALL occur after the reset edge.
REQ-030 In the cycle after reset deasserts, outputs SHALL be the FETCH values.

Verification
REQ-031 Release reset, then apply ADD R1 (Op=00, Funct=001000, Cond=1110) -> State sequence 0,1,6,9,0; RegWrite=1 only in ALUWB; ALUControl=0 in EXECR.
REQ-032 Apply SUBS with ALUFlags=0100, then BEQ -> Z stored; in BRANCH, PCWrite=1 and ALUSrcB=01.
REQ-033 Apply LDR (Op=01, Funct[0]=1) -> states 0,1,2,3,4,0; AdrSrc=1 in MEMRD; RegWrite=1 with ResultSrc=01 in MEMWB.
REQ-034 Apply STRNE with Z=1 -> MEMWR is visited but MemWrite=0; the flag register is unchanged.
REQ-035 Assert reset during MEMWB -> next State=0 with RegWrite=0; with FP_EN=0, Op=11 -> states 0,1,0.

Source files
------------

// File: rtl/mc_controller.sv
// ============================================================================
//  mc_controller
//  Multicycle control FSM: state sequencing, datapath selects, condition
//  evaluation and the NZCV flag register.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller #(
    parameter int ALUCW = 3,
    parameter bit FP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:12]     Instr,
    input  logic [3:0]       ALUFlags,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic             FP,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [ALUCW-1:0] ALUControl,
    output logic [3:0]       State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_EXECF  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_flags;      // {N,Z,C,V}
    logic        r_condex;
    logic        w_cond_met;
    logic [2:0]  w_alu_dec;
    logic [2:0]  w_alu;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic [3:0]  w_rd;
    logic        w_unused_rn;

    assign w_cond      = Instr[31:28];
    assign w_op        = Instr[27:26];
    assign w_funct     = Instr[25:20];
    assign w_rd        = Instr[15:12];
    assign w_unused_rn = &{1'b0, Instr[19:16]};

    assign ImmSrc = w_op;
    assign RegSrc = {w_op == 2'b01, w_op == 2'b10};
    assign State  = r_state;

    always_comb begin
        case (w_funct[4:1])
            4'b0100: w_alu_dec = 3'd0;
            4'b0010: w_alu_dec = 3'd1;
            4'b0000: w_alu_dec = 3'd2;
            4'b1100: w_alu_dec = 3'd3;
            default: w_alu_dec = 3'd7;
        endcase
    end

    always_comb begin
        case (w_cond)
            4'd0:    w_cond_met = r_flags[2];
            4'd1:    w_cond_met = ~r_flags[2];
            4'd2:    w_cond_met = r_flags[1];
            4'd3:    w_cond_met = ~r_flags[1];
            4'd4:    w_cond_met = r_flags[3];
            4'd5:    w_cond_met = ~r_flags[3];
            4'd6:    w_cond_met = r_flags[0];
            4'd7:    w_cond_met = ~r_flags[0];
            4'd8:    w_cond_met = r_flags[1] & ~r_flags[2];
            4'd9:    w_cond_met = ~r_flags[1] | r_flags[2];
            4'd10:   w_cond_met = (r_flags[3] == r_flags[0]);
            4'd11:   w_cond_met = (r_flags[3] != r_flags[0]);
            4'd12:   w_cond_met = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'd13:   w_cond_met = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'd14:   w_cond_met = 1'b1;
            default: w_cond_met = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_flags  <= 4'b0000;
            r_condex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_condex <= w_cond_met;
            // C and V only carry meaning for arithmetic, so logical ops keep them
            if ((r_state == S_EXECR || r_state == S_EXECI || r_state == S_EXECF)
                && w_funct[0] && r_condex) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_alu_dec == 3'd0 || w_alu_dec == 3'd1)
                    r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_next    = S_FETCH;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        FP        = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        w_alu     = 3'd0;
        case (r_state)
            S_FETCH: begin
                w_next    = S_DECODE;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (w_op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = FP_EN ? S_EXECF : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_next  = w_funct[0] ? S_MEMRD : S_MEMWR;
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = r_condex;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = r_condex;
            end
            S_EXECR: begin
                w_next = S_ALUWB;
                w_alu  = w_alu_dec;
            end
            S_EXECI: begin
                w_next  = S_ALUWB;
                ALUSrcB = 2'b01;
                w_alu   = w_alu_dec;
            end
            S_EXECF: begin
                w_next = S_ALUWB;
                FP     = 1'b1;
                w_alu  = w_funct[3:1];
            end
            S_ALUWB: begin
                RegWrite = r_condex;
                PCWrite  = r_condex & (w_rd == 4'd15);
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = r_condex;
            end
            default: w_next = S_FETCH;
        endcase
    end

    generate
        if (ALUCW > 3) begin : g_alu_wide
            assign ALUControl = {{(ALUCW-3){1'b0}}, w_alu};
        end else begin : g_alu_narrow
            assign ALUControl = w_alu;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
//  tb_mc_controller
//  Randomised instruction stream checked against an instruction-level model.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: FP enabled, widened ALUControl
    logic        reset;
    logic [31:12] instr;
    logic [3:0]  alu_flags;
    logic        pcw, irw, rw, mw, adr, asa, fp;
    logic [1:0]  asb, rs, imm, rsrc;
    logic [3:0]  alu_ctl;
    logic [3:0]  st;

    // DUT 1: FP disabled
    logic        reset1;
    logic [31:12] instr1;
    logic        pcw1, irw1, rw1, mw1, adr1, asa1, fp1;
    logic [1:0]  asb1, rs1, imm1, rsrc1;
    logic [2:0]  alu_ctl1;
    logic [3:0]  st1;

    mc_controller #(.ALUCW(4), .FP_EN(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(pcw), .IRWrite(irw), .RegWrite(rw), .MemWrite(mw),
        .AdrSrc(adr), .ALUSrcA(asa), .FP(fp), .ALUSrcB(asb), .ResultSrc(rs),
        .ImmSrc(imm), .RegSrc(rsrc), .ALUControl(alu_ctl), .State(st)
    );

    mc_controller #(.ALUCW(3), .FP_EN(1'b0)) u_dut1 (
        .clk(clk), .reset(reset1), .Instr(instr1), .ALUFlags(4'b0000),
        .PCWrite(pcw1), .IRWrite(irw1), .RegWrite(rw1), .MemWrite(mw1),
        .AdrSrc(adr1), .ALUSrcA(asa1), .FP(fp1), .ALUSrcB(asb1), .ResultSrc(rs1),
        .ImmSrc(imm1), .RegSrc(rsrc1), .ALUControl(alu_ctl1), .State(st1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [3:0] m_flags;   // {N,Z,C,V}
    logic       m_condex;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int alu_op(input logic [3:0] f41);
        if (f41 == 4'b0100) return 0;
        if (f41 == 4'b0010) return 1;
        if (f41 == 4'b0000) return 2;
        if (f41 == 4'b1100) return 3;
        return 7;
    endfunction

    function automatic logic [31:12] mk(input logic [3:0] c, input logic [1:0] op,
                                        input logic [5:0] fn, input logic [3:0] rd);
        return {c, op, fn, 4'h0, rd};
    endfunction

    // expected outputs for the current cycle
    logic       chk = 1'b0;
    logic [3:0] e_st;
    logic       e_pcw, e_irw, e_rw, e_mw, e_adr, e_asa, e_fp;
    logic [1:0] e_asb, e_rs, e_imm, e_rsrc;
    int         e_alu;

    task automatic set_expect(input logic [3:0] s);
        logic [1:0] op;
        op = instr[27:26];
        e_st = s;
        {e_pcw, e_irw, e_rw, e_mw, e_adr, e_asa, e_fp} = '0;
        e_asb = 2'b00; e_rs = 2'b00; e_alu = 0;
        e_imm = op;
        e_rsrc = {op == 2'b01, op == 2'b10};
        case (s)
            4'd0:  begin e_asa = 1; e_asb = 2; e_rs = 2; e_irw = 1; e_pcw = 1; end
            4'd1:  begin e_asa = 1; e_asb = 2; e_rs = 2; end
            4'd2:  e_asb = 1;
            4'd3:  e_adr = 1;
            4'd4:  begin e_rs = 1; e_rw = m_condex; end
            4'd5:  begin e_adr = 1; e_mw = m_condex; end
            4'd6:  e_alu = alu_op(instr[24:21]);
            4'd7:  begin e_asb = 1; e_alu = alu_op(instr[24:21]); end
            4'd8:  begin e_fp = 1; e_alu = int'(instr[23:21]); end
            4'd9:  begin e_rw = m_condex; e_pcw = m_condex && (instr[15:12] == 4'd15); end
            4'd10: begin e_asb = 1; e_rs = 2; e_pcw = m_condex; end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("State",      int'(st),      int'(e_st));
            check("PCWrite",    int'(pcw),     int'(e_pcw));
            check("IRWrite",    int'(irw),     int'(e_irw));
            check("RegWrite",   int'(rw),      int'(e_rw));
            check("MemWrite",   int'(mw),      int'(e_mw));
            check("AdrSrc",     int'(adr),     int'(e_adr));
            check("ALUSrcA",    int'(asa),     int'(e_asa));
            check("FP",         int'(fp),      int'(e_fp));
            check("ALUSrcB",    int'(asb),     int'(e_asb));
            check("ResultSrc",  int'(rs),      int'(e_rs));
            check("ImmSrc",     int'(imm),     int'(e_imm));
            check("RegSrc",     int'(rsrc),    int'(e_rsrc));
            check("ALUControl", int'(alu_ctl), e_alu);
        end
    end

    typedef struct {
        logic [3:0] s;
        logic       rw, mw, pcw, adr;
        logic [1:0] rs, asb;
        logic [3:0] alu;
    } obs_t;
    obs_t seen[$];

    // one clock of an instruction: s is the state the model expects this cycle
    task automatic step(input logic [3:0] s, input bit rnd_fl, input logic [3:0] fl);
        obs_t o;
        alu_flags = rnd_fl ? 4'($urandom) : fl;
        set_expect(s);
        chk = 1'b1;
        @(negedge clk);
        o.s = st; o.rw = rw; o.mw = mw; o.pcw = pcw; o.adr = adr;
        o.rs = rs; o.asb = asb; o.alu = alu_ctl;
        seen.push_back(o);
        @(posedge clk); #1;
        if (reset) begin
            m_flags = 4'b0000;
            m_condex = 1'b0;
        end else begin
            if (s == 4'd1)
                m_condex = cond_ok(instr[31:28], m_flags);
            if ((s == 4'd6 || s == 4'd7 || s == 4'd8) && instr[20] && m_condex) begin
                m_flags[3:2] = alu_flags[3:2];
                if (alu_op(instr[24:21]) <= 1)
                    m_flags[1:0] = alu_flags[1:0];
            end
        end
    endtask

    task automatic run_instr(input logic [31:12] ins, input bit rnd_fl, input logic [3:0] fl);
        seen.delete();
        step(4'd0, rnd_fl, fl);
        instr = ins;
        step(4'd1, rnd_fl, fl);
        case (ins[27:26])
            2'b01: begin
                step(4'd2, rnd_fl, fl);
                if (ins[20]) begin
                    step(4'd3, rnd_fl, fl);
                    step(4'd4, rnd_fl, fl);
                end else begin
                    step(4'd5, rnd_fl, fl);
                end
            end
            2'b00: begin
                step(ins[25] ? 4'd7 : 4'd6, rnd_fl, fl);
                step(4'd9, rnd_fl, fl);
            end
            2'b10: step(4'd10, rnd_fl, fl);
            default: begin
                step(4'd8, rnd_fl, fl);
                step(4'd9, rnd_fl, fl);
            end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] c;
        logic [31:12] add_r1;
        add_r1 = mk(4'b1110, 2'b00, 6'b001000, 4'd1);
        reset = 1'b1; reset1 = 1'b1;
        instr = '0; alu_flags = '0;
        instr1 = mk(4'b1110, 2'b11, 6'b000110, 4'd2);
        m_flags = 4'b0000; m_condex = 1'b0;

        // FP-disabled instance: Op=11 is undefined and returns to FETCH
        repeat (2) @(posedge clk);
        #1 reset1 = 1'b0;
        @(negedge clk); check("nofp_s0", int'(st1), 0);
        @(posedge clk); #1;
        @(negedge clk); check("nofp_s1", int'(st1), 1);
        check("nofp_imm", int'(imm1), 3);
        check("nofp_regsrc", int'(rsrc1), 0);
        @(posedge clk); #1;
        @(negedge clk); check("nofp_s2", int'(st1), 0);
        @(posedge clk); #1 reset1 = 1'b1;

        // main instance out of reset
        @(posedge clk); #1 reset = 1'b0;

        // ADD R1
        run_instr(add_r1, 1'b1, 4'h0);
        check("add_st0", int'(seen[0].s), 0);
        check("add_st2", int'(seen[2].s), 6);
        check("add_st3", int'(seen[3].s), 9);
        check("add_rw_exec", int'(seen[2].rw), 0);
        check("add_rw_wb", int'(seen[3].rw), 1);
        check("add_alu", int'(seen[2].alu), 0);

        // SUBS with Z result, then BEQ
        run_instr(mk(4'b1110, 2'b00, 6'b000101, 4'd3), 1'b0, 4'b0100);
        run_instr(mk(4'b0000, 2'b10, 6'b000000, 4'd0), 1'b1, 4'h0);
        check("beq_st", int'(seen[2].s), 10);
        check("beq_pcw", int'(seen[2].pcw), 1);
        check("beq_asb", int'(seen[2].asb), 1);

        // LDR
        run_instr(mk(4'b1110, 2'b01, 6'b011001, 4'd2), 1'b1, 4'h0);
        check("ldr_st3", int'(seen[3].s), 3);
        check("ldr_st4", int'(seen[4].s), 4);
        check("ldr_adr", int'(seen[3].adr), 1);
        check("ldr_rw", int'(seen[4].rw), 1);
        check("ldr_rs", int'(seen[4].rs), 1);

        // STRNE with Z set: no write, flags untouched
        run_instr(mk(4'b0001, 2'b01, 6'b011000, 4'd2), 1'b1, 4'h0);
        check("strne_st", int'(seen[3].s), 5);
        check("strne_mw", int'(seen[3].mw), 0);
        run_instr(mk(4'b0000, 2'b10, 6'b000000, 4'd0), 1'b1, 4'h0);
        check("beq2_pcw", int'(seen[2].pcw), 1);

        // reset in MEMWB aborts the load
        seen.delete();
        step(4'd0, 1'b1, 4'h0);
        instr = mk(4'b1110, 2'b01, 6'b011001, 4'd4);
        step(4'd1, 1'b1, 4'h0);
        step(4'd2, 1'b1, 4'h0);
        step(4'd3, 1'b1, 4'h0);
        reset = 1'b1;
        step(4'd4, 1'b1, 4'h0);
        reset = 1'b0;
        run_instr(add_r1, 1'b1, 4'h0);
        check("abort_st", int'(seen[0].s), 0);
        check("abort_rw", int'(seen[0].rw), 0);

        // randomised instruction stream
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom);
            run_instr(mk(c, 2'($urandom), 6'($urandom),
                         ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom)),
                      1'b1, 4'h0);
        end

        chk = 1'b0;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
